systolic_array_row_serializer: RTL and testbench

SYSTOLIC_ARRAY_ROW_SERIALIZER -- requirements
Module: systolic_array_row_serializer

---
 rtl/systolic_array_row_serializer.sv | 107 ++++++++++
 tb/tb_systolic_array_row_serializer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_row_serializer.sv
// Row serializer for a systolic array output edge.
// Buffers up to `depth` parallel rows of `array_dim` elements and emits them
// one element per cycle over a valid/ready stream, element 0 first.
// out_last marks the final element of each row, which is the point where the
// head row retires and frees its slot.

module systolic_array_row_serializer #(
   parameter int array_dim = 4,
   parameter int data_w    = 16,
   parameter int depth     = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [data_w*array_dim-1:0]   in_row,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [data_w-1:0]             out_value,
   output logic                          out_last,
   output logic [$clog2(depth):0]        row_count
);

   localparam int ptr_w = $clog2(depth);
   localparam int cnt_w = ptr_w + 1;
   localparam int idx_w = (array_dim > 1) ? $clog2(array_dim) : 1;

   localparam logic [cnt_w-1:0] depth_c  = cnt_w'(depth);
   localparam logic [idx_w-1:0] last_idx = idx_w'(array_dim - 1);

   // Row storage, one entry per buffered row, split into elements.
   logic [data_w-1:0] row_mem [depth][array_dim];

   logic [ptr_w-1:0] wr_ptr;
   logic [ptr_w-1:0] rd_ptr;
   logic [idx_w-1:0] elem_idx;

   logic accept;
   logic xfer;
   logic retire;

   // Handshake decode; flush suppresses both sides so its clear always wins.
   assign accept = in_valid && in_ready && !flush;
   assign xfer   = out_valid && out_ready && !flush;
   assign retire = xfer && out_last;

   // Output decode from registered state only, so in_ready never depends on out_ready.
   always_comb begin
      // NOTE: every output gets a default before any condition so no latch is inferred.
      in_ready  = (row_count < depth_c);
      out_valid = (row_count != '0);
      out_value = '0;
      out_last  = 1'b0;
      if (row_count != '0) begin
         out_value = row_mem[rd_ptr][elem_idx];
         out_last  = (elem_idx == last_idx);
      end
   end

   // Capture an accepted row into the slot at the write pointer.
   // NOTE: the data array carries no reset; validity is tracked by row_count, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < array_dim; k++) begin
            row_mem[wr_ptr][k] <= in_row[k*data_w +: data_w];
         end
      end
   end

   // Pointer, element index and occupancy bookkeeping.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         elem_idx  <= '0;
         row_count <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         elem_idx  <= '0;
         row_count <= '0;
      end else begin
         // depth is a power of two, so natural pointer overflow is the modulo wrap.
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (retire) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (xfer) begin
            if (elem_idx == last_idx) begin
               elem_idx <= '0;
            end else begin
               elem_idx <= elem_idx + 1'b1;
            end
         end
         case ({accept, retire})
            2'b10:   row_count <= row_count + 1'b1;
            2'b01:   row_count <= row_count - 1'b1;
            default: row_count <= row_count;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_array_row_serializer.sv
// Self-checking bench for systolic_array_row_serializer.
// A queue-of-rows reference model predicts every output each cycle; scenario
// tasks add targeted checks for latency, backpressure, wrap, reset and flush.

module tb_systolic_array_row_serializer;

   localparam int DIM   = 4;
   localparam int W     = 16;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef logic [W*DIM-1:0] row_t;

   logic           clk;
   logic           rst;
   logic           flush;
   logic           in_valid;
   logic           in_ready;
   row_t           in_row;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_value;
   logic           out_last;
   logic [CW-1:0]  row_count;

   int errors = 0;
   int checks = 0;

   // Reference model state: rows held, and position within the head row.
   row_t m_q[$];
   int   m_idx      = 0;
   bit   last_acc   = 0;
   int   xfer_count = 0;

   systolic_array_row_serializer #(
      .array_dim (DIM),
      .data_w    (W),
      .depth     (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_row    (in_row),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_value (out_value),
      .out_last  (out_last),
      .row_count (row_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic row_t rand_row();
      return {$urandom(), $urandom()};
   endfunction

   // Compare every output against what the model predicts right now.
   task automatic compare_model(input string tag);
      logic [W-1:0] e_val;
      bit           e_valid;
      bit           e_last;
      e_valid = (m_q.size() != 0);
      e_val   = '0;
      e_last  = 1'b0;
      if (e_valid) begin
         e_val  = m_q[0][m_idx*W +: W];
         e_last = (m_idx == DIM - 1);
      end
      checks += 5;
      if (row_count !== CW'(m_q.size())) begin
         errors++;
         $display("FAIL %s row_count got %0d exp %0d", tag, row_count, m_q.size());
      end
      if (in_ready !== (m_q.size() < DEPTH)) begin
         errors++;
         $display("FAIL %s in_ready got %b exp %b", tag, in_ready, (m_q.size() < DEPTH));
      end
      if (out_valid !== e_valid) begin
         errors++;
         $display("FAIL %s out_valid got %b exp %b", tag, out_valid, e_valid);
      end
      if (out_value !== e_val) begin
         errors++;
         $display("FAIL %s out_value got %h exp %h", tag, out_value, e_val);
      end
      if (out_last !== e_last) begin
         errors++;
         $display("FAIL %s out_last got %b exp %b", tag, out_last, e_last);
      end
   endtask

   // Apply one clock edge to the model using the inputs held across it.
   task automatic model_edge();
      bit acc;
      bit xf;
      acc = in_valid && (m_q.size() < DEPTH) && !flush;
      xf  = out_ready && (m_q.size() != 0) && !flush;
      last_acc = acc;
      if (flush) begin
         m_q.delete();
         m_idx = 0;
      end else begin
         if (xf) begin
            xfer_count++;
            if (m_idx == DIM - 1) begin
               void'(m_q.pop_front());
               m_idx = 0;
            end else begin
               m_idx++;
            end
         end
         if (acc) m_q.push_back(in_row);
      end
   endtask

   // One cycle: check at the falling edge, step across the rising edge.
   task automatic cycle(input string tag);
      compare_model(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      in_row    = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      #1;
      compare_model("reset");
      @(negedge clk);
      rst = 1'b0;
      cycle("post_reset");
   endtask

   task automatic test_basic();
      in_valid = 1'b1;
      in_row   = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
      cycle("basic_accept");
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (out_value !== 16'h3C00) begin
         errors++;
         $display("FAIL basic_latency out_value got %h exp 3c00", out_value);
      end
      for (int i = 0; i < DIM + 1; i++) cycle("basic_drain");
   endtask

   task automatic test_backpressure();
      row_t rows [3];
      rows[0] = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
      rows[1] = rand_row();
      rows[2] = rand_row();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_row   = rows[i];
         cycle("bp_offer");
      end
      in_valid = 1'b0;
      checks += 3;
      if (row_count !== CW'(2)) begin
         errors++;
         $display("FAIL bp_full row_count got %0d exp 2", row_count);
      end
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_full in_ready got %b exp 0", in_ready);
      end
      if (out_value !== 16'h3C00) begin
         errors++;
         $display("FAIL bp_hold out_value got %h exp 3c00", out_value);
      end
      for (int i = 0; i < 2; i++) cycle("bp_stall");
      // Drain to the last element of the head row, then offer a row on the retire edge.
      out_ready = 1'b1;
      for (int i = 0; i < DIM - 1; i++) cycle("sim_drain");
      in_valid = 1'b1;
      in_row   = rand_row();
      checks++;
      if (in_ready !== 1'b0 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL sim_edge in_ready/out_last got %b/%b exp 0/1", in_ready, out_last);
      end
      cycle("sim_retire");
      in_valid = 1'b0;
      checks += 2;
      if (row_count !== CW'(1)) begin
         errors++;
         $display("FAIL sim_after row_count got %0d exp 1", row_count);
      end
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL sim_after in_ready got %b exp 1", in_ready);
      end
      for (int i = 0; i < DIM + 1; i++) cycle("sim_flushout");
   endtask

   task automatic test_stream_wrap();
      row_t rows [5];
      int   sent    = 0;
      int   gaps    = 0;
      bit   started = 0;
      int   budget  = 0;
      foreach (rows[i]) rows[i] = rand_row();
      xfer_count = 0;
      out_ready  = 1'b1;
      while (xfer_count < 5 * DIM && budget < 60) begin
         in_valid = (sent < 5);
         in_row   = (sent < 5) ? rows[sent] : '0;
         if (out_valid) started = 1;
         else if (started) gaps++;
         cycle("stream");
         if (last_acc) sent++;
         budget++;
      end
      in_valid = 1'b0;
      checks += 3;
      if (xfer_count !== 5 * DIM) begin
         errors++;
         $display("FAIL stream_count got %0d exp %0d", xfer_count, 5 * DIM);
      end
      if (sent !== 5) begin
         errors++;
         $display("FAIL stream_rows got %0d exp 5", sent);
      end
      if (gaps !== 0) begin
         errors++;
         $display("FAIL stream_gaps got %0d exp 0", gaps);
      end
      cycle("stream_idle");
   endtask

   task automatic test_reset_mid_row();
      row_t r;
      in_valid = 1'b1;
      in_row   = rand_row();
      cycle("rm_accept");
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cycle("rm_drain");
      cycle("rm_drain");
      #2;
      rst = 1'b1;
      #1;
      m_q.delete();
      m_idx = 0;
      compare_model("rm_async");
      @(negedge clk);
      rst = 1'b0;
      r        = rand_row();
      in_valid = 1'b1;
      in_row   = r;
      cycle("rm_reaccept");
      in_valid = 1'b0;
      checks++;
      if (out_value !== r[W-1:0]) begin
         errors++;
         $display("FAIL rm_elem0 out_value got %h exp %h", out_value, r[W-1:0]);
      end
      for (int i = 0; i < DIM + 1; i++) cycle("rm_drain2");
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_row = rand_row();
         cycle("fl_fill");
      end
      in_row    = rand_row();
      flush     = 1'b1;
      out_ready = 1'b1;
      cycle("fl_flush");
      flush    = 1'b0;
      in_valid = 1'b0;
      checks += 2;
      if (row_count !== '0) begin
         errors++;
         $display("FAIL fl_count row_count got %0d exp 0", row_count);
      end
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL fl_valid out_valid got %b exp 0", out_valid);
      end
      cycle("fl_after");
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid  = $urandom_range(0, 1);
         in_row    = rand_row();
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 49) == 0);
         cycle("random");
      end
      idle_inputs();
      cycle("random_end");
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_basic();
      test_backpressure();
      test_stream_wrap();
      test_reset_mid_row();
      test_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
